// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Brief    : Stall/flush sequencer for the 5-stage pipeline. It handles
//            load-use stalls, taken-branch flushes and data-memory wait freezes.
//            The optional build macro PIPE_PERF_COUNTERS_EN adds performance
//            counters.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller #(
   parameter int REG_ADDR_WIDTH    = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int MEM_TIMEOUT       = 64
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic [REG_ADDR_WIDTH-1:0] idRs1,
   input  logic [REG_ADDR_WIDTH-1:0] idRs2,
   input  logic                      idUsesRs1,
   input  logic                      idUsesRs2,
   input  logic [REG_ADDR_WIDTH-1:0] exRd,
   input  logic                      exIsMemRead,
   input  logic                      exBranchTaken,
   input  logic                      memRequest,
   input  logic                      memReady,
   output logic                      pcWrite,
   output logic                      ifIdWrite,
   output logic                      ifIdFlush,
   output logic                      idExWrite,
   output logic                      idExFlush,
   output logic                      exMemWrite,
   output logic                      memWbBubble,
`ifdef PIPE_PERF_COUNTERS_EN
   output logic [31:0]               stallCycles,
   output logic [31:0]               flushCount,
   output logic [31:0]               memWaitCycles,
`endif
   output logic                      memTimeout
);

   localparam int                  c_WAIT_W       = $clog2(MEM_TIMEOUT);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST    = c_WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [1:0]          c_STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);
   localparam bit                  c_MULTI_STALL  = (LOAD_STALL_CYCLES > 1);

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MEM_WAIT   = 2'd2
   } state_t;

   state_t              r_state, r_retState;
   state_t              w_nextState, w_nextRet, w_effState;
   logic [1:0]          r_stallCnt, w_nextStallCnt;
   logic [c_WAIT_W-1:0] r_waitCnt, w_nextWaitCnt;
   logic                r_memTimeout, w_nextTimeout;
   logic                w_frozen, w_loadUse;

   assign w_frozen  = memRequest & ~memReady;
   assign w_loadUse = exIsMemRead & (exRd != '0) &
                      ((idUsesRs1 & (idRs1 == exRd)) | (idUsesRs2 & (idRs2 == exRd)));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state      <= ST_RUN;
         r_retState   <= ST_RUN;
         r_stallCnt   <= '0;
         r_waitCnt    <= '0;
         r_memTimeout <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_retState   <= w_nextRet;
         r_stallCnt   <= w_nextStallCnt;
         r_waitCnt    <= w_nextWaitCnt;
         r_memTimeout <= w_nextTimeout;
      end
   end

   always_comb begin
      pcWrite        = 1'b1;
      ifIdWrite      = 1'b1;
      ifIdFlush      = 1'b0;
      idExWrite      = 1'b1;
      idExFlush      = 1'b0;
      exMemWrite     = 1'b1;
      memWbBubble    = 1'b0;
      w_nextState    = r_state;
      w_nextRet      = r_retState;
      w_nextStallCnt = r_stallCnt;
      w_nextWaitCnt  = r_waitCnt;
      w_nextTimeout  = r_memTimeout;
      // Leaving a memory wait resumes whatever the pipeline was doing before it.
      w_effState     = (r_state == ST_MEM_WAIT) ? r_retState : r_state;

      if (w_frozen) begin
         pcWrite     = 1'b0;
         ifIdWrite   = 1'b0;
         idExWrite   = 1'b0;
         exMemWrite  = 1'b0;
         memWbBubble = 1'b1;
         w_nextState = ST_MEM_WAIT;
         if (r_state != ST_MEM_WAIT) begin
            w_nextRet = r_state;
         end
         if (r_waitCnt == c_WAIT_LAST) begin
            w_nextTimeout = 1'b1;
         end else begin
            w_nextWaitCnt = r_waitCnt + 1'b1;
         end
      end else begin
         w_nextWaitCnt = '0;
         if (exBranchTaken) begin
            ifIdFlush      = 1'b1;
            idExFlush      = 1'b1;
            w_nextState    = ST_RUN;
            w_nextStallCnt = '0;
         end else if ((w_effState == ST_LOAD_STALL) || w_loadUse) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
            // The hazard is not re-evaluated while bubbles are still owed.
            if (w_effState == ST_LOAD_STALL) begin
               if (r_stallCnt <= 2'd1) begin
                  w_nextState    = ST_RUN;
                  w_nextStallCnt = '0;
               end else begin
                  w_nextState    = ST_LOAD_STALL;
                  w_nextStallCnt = r_stallCnt - 2'd1;
               end
            end else if (c_MULTI_STALL) begin
               w_nextState    = ST_LOAD_STALL;
               w_nextStallCnt = c_STALL_RELOAD;
            end else begin
               w_nextState = ST_RUN;
            end
         end else begin
            w_nextState = ST_RUN;
         end
      end

      if (!resetN) begin
         pcWrite     = 1'b0;
         ifIdWrite   = 1'b0;
         ifIdFlush   = 1'b1;
         idExWrite   = 1'b0;
         idExFlush   = 1'b1;
         exMemWrite  = 1'b0;
         memWbBubble = 1'b1;
      end
   end

   assign memTimeout = r_memTimeout;

`ifdef PIPE_PERF_COUNTERS_EN
   logic [31:0] r_stallCycles, r_flushCount, r_memWaitCycles;

   // A load-use stall is the only event that flushes ID/EX without IF/ID.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_stallCycles   <= '0;
         r_flushCount    <= '0;
         r_memWaitCycles <= '0;
      end else begin
         if (idExFlush && !ifIdFlush) r_stallCycles   <= r_stallCycles + 32'd1;
         if (ifIdFlush)               r_flushCount    <= r_flushCount + 32'd1;
         if (w_frozen)                r_memWaitCycles <= r_memWaitCycles + 32'd1;
      end
   end

   assign stallCycles   = r_stallCycles;
   assign flushCount    = r_flushCount;
   assign memWaitCycles = r_memWaitCycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// Scoreboard bench: three controller configurations share one random/directed
// stimulus stream and are compared against an owed-bubble reference model.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic [4:0] idRs1 = '0, idRs2 = '0, exRd = '0;
   logic       idUsesRs1 = 1'b0, idUsesRs2 = 1'b0, exIsMemRead = 1'b0;
   logic       exBranchTaken = 1'b0, memRequest = 1'b0, memReady = 1'b0;
   wire  [7:0] outA, outB, outC;

   int         stallLen [3] = '{1, 2, 3};
   int         timeoutLen [3] = '{4, 6, 64};
   int         pend [3];
   int         wcnt [3];
   bit         tmo [3];
   logic [23:0] expQ [$];
   int         compared = 0;
   int         mismatched = 0;
   int         cyc = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4)) dutA (
      .clk(clk), .resetN(resetN), .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1),
      .idUsesRs2(idUsesRs2), .exRd(exRd), .exIsMemRead(exIsMemRead),
      .exBranchTaken(exBranchTaken), .memRequest(memRequest), .memReady(memReady),
      .pcWrite(outA[7]), .ifIdWrite(outA[6]), .ifIdFlush(outA[5]), .idExWrite(outA[4]),
      .idExFlush(outA[3]), .exMemWrite(outA[2]), .memWbBubble(outA[1]), .memTimeout(outA[0]));

   pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(6)) dutB (
      .clk(clk), .resetN(resetN), .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1),
      .idUsesRs2(idUsesRs2), .exRd(exRd), .exIsMemRead(exIsMemRead),
      .exBranchTaken(exBranchTaken), .memRequest(memRequest), .memReady(memReady),
      .pcWrite(outB[7]), .ifIdWrite(outB[6]), .ifIdFlush(outB[5]), .idExWrite(outB[4]),
      .idExFlush(outB[3]), .exMemWrite(outB[2]), .memWbBubble(outB[1]), .memTimeout(outB[0]));

   pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(64)) dutC (
      .clk(clk), .resetN(resetN), .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1),
      .idUsesRs2(idUsesRs2), .exRd(exRd), .exIsMemRead(exIsMemRead),
      .exBranchTaken(exBranchTaken), .memRequest(memRequest), .memReady(memReady),
      .pcWrite(outC[7]), .ifIdWrite(outC[6]), .ifIdFlush(outC[5]), .idExWrite(outC[4]),
      .idExFlush(outC[3]), .exMemWrite(outC[2]), .memWbBubble(outC[1]), .memTimeout(outC[0]));

   // Expected {pcWrite,ifIdWrite,ifIdFlush,idExWrite,idExFlush,exMemWrite,memWbBubble,memTimeout}
   // for configuration i this cycle; pend counts load-use bubbles still owed.
   function automatic logic [7:0] modelStep(input int i);
      logic hz;
      if (!resetN) begin
         pend[i] = 0;
         wcnt[i] = 0;
         tmo[i]  = 1'b0;
         return 8'b0010_1010;
      end
      hz = exIsMemRead && (exRd != 5'd0) &&
           ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
      if (memRequest && !memReady) begin
         modelStep = {7'b0000001, tmo[i]};
         wcnt[i] = wcnt[i] + 1;
         if (wcnt[i] >= timeoutLen[i]) tmo[i] = 1'b1;
         return modelStep;
      end
      wcnt[i] = 0;
      if (exBranchTaken) begin
         pend[i] = 0;
         return {7'b1111110, tmo[i]};
      end
      if (pend[i] > 0) begin
         pend[i] = pend[i] - 1;
         return {7'b0001110, tmo[i]};
      end
      if (hz) begin
         pend[i] = stallLen[i] - 1;
         return {7'b0001110, tmo[i]};
      end
      return {7'b1101010, tmo[i]};
   endfunction

   task automatic drive(input logic rn, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic rq, input logic ry);
      logic [23:0] e;
      @(posedge clk);
      #1;
      resetN = rn; idRs1 = r1; idRs2 = r2; idUsesRs1 = u1; idUsesRs2 = u2;
      exRd = rd; exIsMemRead = mr; exBranchTaken = br; memRequest = rq; memReady = ry;
      for (int i = 0; i < 3; i++) e[i*8 +: 8] = modelStep(i);
      expQ.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      logic [23:0] e, got;
      if (expQ.size() > 0) begin
         e   = expQ.pop_front();
         got = {outC, outB, outA};
         for (int i = 0; i < 3; i++) begin
            compared = compared + 1;
            if (got[i*8 +: 8] !== e[i*8 +: 8]) begin
               mismatched = mismatched + 1;
               $display("FAIL outputs dut%0d cycle %0d: got %b expected %b", i, cyc, got[i*8 +: 8], e[i*8 +: 8]);
            end
         end
         cyc = cyc + 1;
      end
   end

   initial begin
      // Reset held low: safe outputs.
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      // lw x5 in EX, ID reads x5 via rs2.
      drive(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      // Destination x0, then rs2 not used: no stall.
      drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd1, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      // Hazard through rs1, hazard inputs left asserted during the stall.
      drive(1'b1, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      // Branch together with load-use: flush wins.
      drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
      // Memory wait of 3 cycles with a branch held in EX; release flushes.
      for (int k = 0; k < 3; k++) drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(2);
      // Freeze in the middle of a multi-cycle load stall.
      drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(4);
      // Long wait: timeouts of the short configurations assert and stay set.
      for (int k = 0; k < 8; k++) drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(2);
      // Reset pulse in the middle of a wait.
      for (int k = 0; k < 3; k++) drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      // Random traffic over a small register set so hazards are frequent.
      for (int k = 0; k < 3000; k++) begin
         logic rq;
         rq = ($urandom_range(0, 99) < 30);
         drive(($urandom_range(0, 299) != 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 10),
               rq, rq && ($urandom_range(0, 99) < 40));
      end
      @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         compared = compared + 1;
         mismatched = mismatched + 1;
         $display("FAIL drain: %0d expectations left, required 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
